// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU divide sequencer: rounding modes, flag
// positions, canonical constants, operand classes and sequencer states.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } op_class_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ROUND,
    S_RESP,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/fpu_div_round.sv
// Combinational round-and-pack of the divider's normalised 27-bit significand
// into a binary32 result with {NV,DZ,OF,UF,NX} flags.
module fpu_div_round
  import fpu_pkg::*;
(
  input  logic [26:0] sig,
  input  logic [7:0]  exp,
  input  logic        sign,
  input  logic [2:0]  rm,
  input  logic        of_in,
  input  logic        uf_in,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  logic        g, r, s, lsb, nx, inc, ovf, sat;
  logic [24:0] sig_sum;
  logic [8:0]  exp_rnd;
  logic [22:0] man_rnd;

  assign g   = sig[2];
  assign r   = sig[1];
  assign s   = sig[0];
  assign lsb = sig[3];
  assign nx  = g | r | s;

  always_comb begin
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & nx;
      RM_RUP:  inc = ~sign & nx;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

  // A denormal that rounds up into the hidden bit becomes exponent 1.
  assign sig_sum = {1'b0, sig[26:3]} + 25'(inc);
  assign exp_rnd = {1'b0, exp} + 9'(sig_sum[24]) + 9'((exp == 8'd0) & sig_sum[23]);
  assign man_rnd = sig_sum[24] ? 23'd0 : sig_sum[22:0];
  assign ovf     = of_in | (exp_rnd >= 9'd255);

  always_comb begin
    case (rm)
      RM_RTZ:  sat = 1'b1;
      RM_RDN:  sat = ~sign;
      RM_RUP:  sat = sign;
      default: sat = 1'b0;
    endcase
  end

  always_comb begin
    result          = {sign, exp_rnd[7:0], man_rnd};
    fflags          = '0;
    fflags[FLAG_NX] = nx;
    fflags[FLAG_UF] = uf_in & nx;
    if (ovf) begin
      result          = sat ? {sign, MAX_FINITE[30:0]} : {sign, 8'hFF, 23'd0};
      fflags          = '0;
      fflags[FLAG_OF] = 1'b1;
      fflags[FLAG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_div_ctrl.sv
// Initiator-side sequencer for the FPU divider: classifies operands, resolves
// special cases locally, drives the divider and rounds its result.
module fpu_div_ctrl
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [2:0]  rm,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags,
  output logic        div_start,
  output logic [23:0] sig_A,
  output logic [23:0] sig_B,
  output logic [8:0]  preNorm_exp,
  output logic        is_exp_underFlow,
  input  logic [26:0] div_proNorm_sig,
  input  logic [7:0]  div_proNorm_exp,
  input  logic        div_rdy,
  input  logic        OF_from_proNorm,
  input  logic        UF_from_proNorm
);

  state_t      state, state_nxt;
  op_class_t   cls_a, cls_b;
  logic [2:0]  rm_q;
  logic        sign_q, sign_in, accept, special;
  logic [7:0]  exp_a, exp_b, eff_a, eff_b;
  logic [22:0] man_a, man_b;
  logic [9:0]  exp_diff;
  logic [31:0] spec_result, rnd_result;
  logic [4:0]  spec_flags, rnd_flags;

  assign exp_a   = op_a[30:23];
  assign exp_b   = op_b[30:23];
  assign man_a   = op_a[22:0];
  assign man_b   = op_b[22:0];
  assign sign_in = op_a[31] ^ op_b[31];

  function automatic op_class_t classify(input logic [7:0] e, input logic [22:0] m);
    if (e == 8'd0)        return (m == 23'd0) ? CLS_ZERO : CLS_DENORM;
    else if (e == 8'hFF)  return (m == 23'd0) ? CLS_INF : (m[22] ? CLS_QNAN : CLS_SNAN);
    else                  return CLS_NORMAL;
  endfunction

  assign cls_a = classify(exp_a, man_a);
  assign cls_b = classify(exp_b, man_b);

  always_comb begin
    special     = 1'b1;
    spec_result = CANON_NAN;
    spec_flags  = '0;
    if (cls_a == CLS_SNAN || cls_b == CLS_SNAN)
      spec_flags[FLAG_NV] = 1'b1;
    else if (cls_a == CLS_QNAN || cls_b == CLS_QNAN)
      spec_flags = '0;
    else if ((cls_a == CLS_INF && cls_b == CLS_INF) || (cls_a == CLS_ZERO && cls_b == CLS_ZERO))
      spec_flags[FLAG_NV] = 1'b1;
    else if (cls_b == CLS_ZERO && cls_a != CLS_INF) begin
      spec_result         = {sign_in, 8'hFF, 23'd0};
      spec_flags[FLAG_DZ] = 1'b1;
    end
    else if (cls_a == CLS_INF)
      spec_result = {sign_in, 8'hFF, 23'd0};
    else if (cls_b == CLS_INF || cls_a == CLS_ZERO)
      spec_result = {sign_in, 31'd0};
    else
      special = 1'b0;
  end

  // Denormals enter the exponent difference as exponent 1.
  assign eff_a    = (exp_a == 8'd0) ? 8'd1 : exp_a;
  assign eff_b    = (exp_b == 8'd0) ? 8'd1 : exp_b;
  assign exp_diff = 10'(eff_a) - 10'(eff_b) + 10'd127;

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = special ? S_RESP : S_START;
      S_START: state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush)        state_nxt = div_rdy ? S_IDLE : S_DRAIN;
        else if (div_rdy) state_nxt = S_ROUND;
      end
      S_ROUND: state_nxt = flush ? S_IDLE : S_RESP;
      S_RESP:  if (flush || resp_ready) state_nxt = S_IDLE;
      S_DRAIN: if (div_rdy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE) & ~flush;
    div_start  = (state == S_START);
    resp_valid = (state == S_RESP) & ~flush;
  end

  fpu_div_round u_round (
    .sig    (div_proNorm_sig),
    .exp    (div_proNorm_exp),
    .sign   (sign_q),
    .rm     (rm_q),
    .of_in  (OF_from_proNorm),
    .uf_in  (UF_from_proNorm),
    .result (rnd_result),
    .fflags (rnd_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rm_q             <= RM_RNE;
      sign_q           <= 1'b0;
      sig_A            <= '0;
      sig_B            <= '0;
      preNorm_exp      <= '0;
      is_exp_underFlow <= 1'b0;
      result           <= '0;
      fflags           <= '0;
    end else begin
      if (accept) begin
        rm_q             <= rm;
        sign_q           <= sign_in;
        sig_A            <= {exp_a != 8'd0, man_a};
        sig_B            <= {exp_b != 8'd0, man_b};
        preNorm_exp      <= exp_diff[8:0];
        is_exp_underFlow <= ($signed(exp_diff) < 10'sd1);
        if (special) begin
          result <= spec_result;
          fflags <= spec_flags;
        end
      end
      if (state == S_ROUND && !flush) begin
        result <= rnd_result;
        fflags <= rnd_flags;
      end
    end
  end

endmodule
